// File: rtl/dht22_pkg.sv
// Shared definitions for the DHT22 AXI4-Lite register bank.
package dht22_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned BCD_W    = 12;
    localparam int unsigned PARITY_W = 8;

    // Register byte offsets
    localparam logic [ADDR_W-1:0] REG_CTRL   = 5'h00;
    localparam logic [ADDR_W-1:0] REG_STATUS = 5'h04;
    localparam logic [ADDR_W-1:0] REG_DATA   = 5'h08;
    localparam logic [ADDR_W-1:0] REG_PERIOD = 5'h0C;
    localparam logic [ADDR_W-1:0] REG_COUNT  = 5'h10;
    localparam logic [ADDR_W-1:0] REG_PARITY = 5'h14;

    // CTRL / STATUS bit positions
    localparam int unsigned CTRL_START_BIT   = 0;
    localparam int unsigned CTRL_AUTO_EN_BIT = 1;
    localparam int unsigned STAT_IDLE_BIT    = 0;
    localparam int unsigned STAT_VALID_BIT   = 1;
    localparam int unsigned STAT_PENDING_BIT = 2;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One captured sensor reading
    typedef struct packed {
        logic                neg;
        logic [BCD_W-1:0]    temp_bcd;
        logic [BCD_W-1:0]    hum_bcd;
        logic [PARITY_W-1:0] parity;
    } dht22_sample_t;

    // Byte-strobe merge of a write into an existing register value
    function automatic logic [DATA_W-1:0] strb_merge(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_val[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // True for word-aligned offsets inside the register map
    function automatic logic addr_mapped(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00) && (addr <= REG_PARITY);
    endfunction

    // DATA register layout: [31] sign, [27:16] temperature, [11:0] humidity
    function automatic logic [DATA_W-1:0] sample_to_data(input dht22_sample_t s);
        return {s.neg, 3'b000, s.temp_bcd, 4'h0, s.hum_bcd};
    endfunction

endpackage

// File: rtl/dht22_trigger_sched.sv
// Auto-trigger timer, pending request flag and start_read pulse generation.
module dht22_trigger_sched
    import dht22_pkg::*;
(
    input  logic              clk,
    input  logic              arstn,
    input  logic              auto_en_i,
    input  logic [DATA_W-1:0] period_i,
    input  logic              start_set_i,
    input  logic              sys_idle_i,
    output logic              start_read_o,
    output logic              pending_o
);

    logic [DATA_W-1:0] timer_q, timer_d;
    logic              pending_q, pending_d;
    logic              start_q, start_d;
    logic              fire;
    logic              expire;

    // Next-state: a request fires when the driver is idle; firing beats any new set
    always_comb begin
        timer_d   = timer_q;
        pending_d = pending_q;
        start_d   = 1'b0;
        fire      = pending_q && sys_idle_i;
        expire    = auto_en_i && (timer_q == (period_i - DATA_W'(1)));

        if (!auto_en_i) begin
            timer_d = '0;
        end else if (expire) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + DATA_W'(1);
        end

        if (fire) begin
            pending_d = 1'b0;
            start_d   = 1'b1;
        end else if (start_set_i || expire) begin
            pending_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            timer_q   <= '0;
            pending_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
            start_q   <= start_d;
        end
    end

    assign start_read_o = start_q;
    assign pending_o    = pending_q;

endmodule

// File: rtl/axi_lite_dht22_regs.sv
// AXI4-Lite register bank for the DHT22 sensor: control, status, atomic snapshot.
module axi_lite_dht22_regs
    import dht22_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned MIN_PERIOD = 2 * CLK_FREQ
) (
    input  logic                clk,
    input  logic                arstn,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [STRB_W-1:0]   s_wstrb,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic                start_read,
    input  logic                data_ready,
    input  logic                sys_idle,
    input  logic [BCD_W-1:0]    humidity_bcd,
    input  logic [BCD_W-1:0]    temperature_bcd,
    input  logic                negativo_temp,
    input  logic [PARITY_W-1:0] parity
);

    localparam logic [DATA_W-1:0] MIN_P = DATA_W'(MIN_PERIOD);

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_state_e;

    wr_state_e         wstate_q, wstate_d;
    rd_state_e         rstate_q, rstate_d;
    logic              awready_q, awready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              auto_en_q, auto_en_d;
    logic [DATA_W-1:0] period_q, period_d;
    logic              valid_q, valid_d;
    dht22_sample_t     sample_q, sample_d;
    logic [DATA_W-1:0] count_q, count_d;

    logic              wr_en;
    logic              start_set;
    logic              pending;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] rd_mux;

    // Write channel: accept address+data together, then hold the response until bready
    always_comb begin
        wstate_d  = wstate_q;
        awready_d = 1'b0;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_en     = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (s_awvalid && s_wvalid && !bvalid_q) begin
                    awready_d = 1'b1;
                    wstate_d  = W_ACK;
                end
            end
            W_ACK: begin
                wr_en    = 1'b1;
                bvalid_d = 1'b1;
                bresp_d  = addr_mapped(s_awaddr) ? RESP_OKAY : RESP_SLVERR;
                wstate_d = W_RESP;
            end
            W_RESP: begin
                if (s_bready) begin
                    bvalid_d = 1'b0;
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Write channel state register
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Read data mux over the current register contents
    always_comb begin
        rd_mux = '0;
        case (s_araddr)
            REG_CTRL:   rd_mux[CTRL_AUTO_EN_BIT] = auto_en_q;
            REG_STATUS: begin
                rd_mux[STAT_IDLE_BIT]    = sys_idle;
                rd_mux[STAT_VALID_BIT]   = valid_q;
                rd_mux[STAT_PENDING_BIT] = pending;
            end
            REG_DATA:   rd_mux = sample_to_data(sample_q);
            REG_PERIOD: rd_mux = period_q;
            REG_COUNT:  rd_mux = count_q;
            REG_PARITY: rd_mux = DATA_W'(sample_q.parity);
            default:    rd_mux = '0;
        endcase
    end

    // Read channel: latch data at the handshake and hold it until rready
    always_comb begin
        rstate_d  = rstate_q;
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (rstate_q)
            R_IDLE: begin
                if (s_arvalid && !rvalid_q) begin
                    arready_d = 1'b1;
                    rstate_d  = R_ACK;
                end
            end
            R_ACK: begin
                rvalid_d = 1'b1;
                rdata_d  = rd_mux;
                rresp_d  = addr_mapped(s_araddr) ? RESP_OKAY : RESP_SLVERR;
                rstate_d = R_DATA;
            end
            R_DATA: begin
                if (s_rready) begin
                    rvalid_d = 1'b0;
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read channel state register
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Register bank updates; a capture is applied after W1C so a new reading wins
    always_comb begin
        auto_en_d = auto_en_q;
        period_d  = period_q;
        valid_d   = valid_q;
        sample_d  = sample_q;
        count_d   = count_q;
        start_set = 1'b0;
        merged    = strb_merge(period_q, s_wdata, s_wstrb);

        if (wr_en && addr_mapped(s_awaddr)) begin
            case (s_awaddr)
                REG_CTRL: begin
                    if (s_wstrb[0]) begin
                        auto_en_d = s_wdata[CTRL_AUTO_EN_BIT];
                        start_set = s_wdata[CTRL_START_BIT];
                    end
                end
                REG_STATUS: begin
                    if (s_wdata[STAT_VALID_BIT]) begin
                        valid_d = 1'b0;
                    end
                end
                REG_PERIOD: period_d = (merged < MIN_P) ? MIN_P : merged;
                default: ;
            endcase
        end

        if (data_ready) begin
            sample_d.neg      = negativo_temp;
            sample_d.temp_bcd = temperature_bcd;
            sample_d.hum_bcd  = humidity_bcd;
            sample_d.parity   = parity;
            valid_d           = 1'b1;
            count_d           = count_q + DATA_W'(1);
        end
    end

    // Register bank state
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            auto_en_q <= 1'b0;
            period_q  <= MIN_P;
            valid_q   <= 1'b0;
            sample_q  <= '0;
            count_q   <= '0;
        end else begin
            auto_en_q <= auto_en_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            sample_q  <= sample_d;
            count_q   <= count_d;
        end
    end

    dht22_trigger_sched u_sched (
        .clk          (clk),
        .arstn        (arstn),
        .auto_en_i    (auto_en_q),
        .period_i     (period_q),
        .start_set_i  (start_set),
        .sys_idle_i   (sys_idle),
        .start_read_o (start_read),
        .pending_o    (pending)
    );

    assign s_awready = awready_q;
    assign s_wready  = awready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_dht22_regs.sv
// Self-checking bench for axi_lite_dht22_regs with a behavioural register/trigger model.
module tb_axi_lite_dht22_regs;

    localparam int unsigned CLKF = 1000;
    localparam int unsigned MINP = 2 * CLKF;

    logic        clk;
    logic        arstn;
    logic [4:0]  s_awaddr;
    logic        s_awvalid, s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid, s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid, s_bready;
    logic [4:0]  s_araddr;
    logic        s_arvalid, s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid, s_rready;
    logic        start_read, data_ready, sys_idle;
    logic [11:0] humidity_bcd, temperature_bcd;
    logic        negativo_temp;
    logic [7:0]  parity;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int pulse_q[$];

    // model state
    bit          m_auto, m_valid, m_pending, m_start;
    int unsigned m_period, m_timer, m_count;
    logic [31:0] m_data;
    logic [7:0]  m_par;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp, exp_bresp;

    // handshake notifications from the stimulus tasks to the model
    bit          wr_fire, rd_fire;
    logic [4:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    axi_lite_dht22_regs #(.CLK_FREQ(CLKF)) dut (
        .clk(clk), .arstn(arstn),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .start_read(start_read), .data_ready(data_ready), .sys_idle(sys_idle),
        .humidity_bcd(humidity_bcd), .temperature_bcd(temperature_bcd),
        .negativo_temp(negativo_temp), .parity(parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_mapped(input logic [4:0] a);
        return (a[1:0] == 2'b00) && (int'(a) <= 20);
    endfunction

    // Register file view as seen by software
    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] regs [6];
        regs[0] = {30'd0, m_auto, 1'b0};
        regs[1] = {29'd0, m_pending, m_valid, sys_idle};
        regs[2] = m_data;
        regs[3] = m_period;
        regs[4] = m_count;
        regs[5] = {24'd0, m_par};
        if (!is_mapped(a)) return 32'd0;
        return regs[int'(a) / 4];
    endfunction

    // Behavioural model: evaluated once per clock edge on the pre-edge state
    always @(posedge clk or negedge arstn) begin : model
        bit          fire, expire, set;
        logic [31:0] merged;
        if (!arstn) begin
            m_auto = 0; m_valid = 0; m_pending = 0; m_start = 0;
            m_period = MINP; m_timer = 0; m_count = 0; m_data = 0; m_par = 0;
            exp_rdata = 0; exp_rresp = 0; exp_bresp = 0;
        end else begin
            cyc++;
            if (rd_fire) begin
                exp_rdata = model_read(rd_addr);
                exp_rresp = is_mapped(rd_addr) ? 2'b00 : 2'b10;
            end
            if (wr_fire) exp_bresp = is_mapped(wr_addr) ? 2'b00 : 2'b10;
            fire   = m_pending && sys_idle;
            expire = m_auto && (m_timer == m_period - 1);
            m_timer = !m_auto ? 0 : (expire ? 0 : m_timer + 1);
            set = expire || (wr_fire && wr_addr == 5'h00 && wr_strb[0] && wr_data[0]);
            m_start   = fire;
            m_pending = fire ? 1'b0 : (m_pending || set);
            if (wr_fire) begin
                if (wr_addr == 5'h00 && wr_strb[0]) m_auto = wr_data[1];
                if (wr_addr == 5'h04 && wr_data[1]) m_valid = 0;
                if (wr_addr == 5'h0C) begin
                    merged = m_period;
                    for (int b = 0; b < 4; b++) if (wr_strb[b]) merged[b*8 +: 8] = wr_data[b*8 +: 8];
                    m_period = (merged < MINP) ? MINP : merged;
                end
            end
            if (data_ready) begin
                m_data  = {negativo_temp, 3'd0, temperature_bcd, 4'd0, humidity_bcd};
                m_par   = parity;
                m_valid = 1;
                m_count = m_count + 1;
            end
        end
    end

    // Every-cycle comparison of the trigger output
    always @(negedge clk) begin
        if (arstn) begin
            check("start_read", 32'(start_read), 32'(m_start));
            if (start_read) pulse_q.push_back(cyc);
        end
    end

    task automatic sensor_rand();
        humidity_bcd    = 12'($urandom);
        temperature_bcd = 12'($urandom);
        negativo_temp   = 1'($urandom);
        parity          = 8'($urandom);
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int hold, input bit dr, output logic [1:0] r);
        bit seen;
        logic [1:0] r0;
        seen = 0; r = 2'b11;
        @(negedge clk);
        s_awaddr = a; s_wdata = d; s_wstrb = s; s_awvalid = 1; s_wvalid = 1; s_bready = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (s_awready) begin seen = 1; break; end
        end
        check("awready_seen", 32'(seen), 32'd1);
        if (!seen) begin s_awvalid = 0; s_wvalid = 0; return; end
        check("wready", 32'(s_wready), 32'd1);
        wr_fire = 1; wr_addr = a; wr_data = d; wr_strb = s;
        if (dr) begin sensor_rand(); data_ready = 1; end
        @(negedge clk);
        s_awvalid = 0; s_wvalid = 0; wr_fire = 0; data_ready = 0;
        check("bvalid", 32'(s_bvalid), 32'd1);
        check("bresp", 32'(s_bresp), 32'(exp_bresp));
        r0 = s_bresp;
        repeat (hold) begin
            @(negedge clk);
            check("bvalid_hold", 32'(s_bvalid), 32'd1);
            check("bresp_hold", 32'(s_bresp), 32'(r0));
        end
        s_bready = 1;
        @(negedge clk);
        s_bready = 0;
        check("bvalid_clr", 32'(s_bvalid), 32'd0);
        r = r0;
    endtask

    task automatic axi_read(input logic [4:0] a, input int hold, input bit dr,
                            output logic [31:0] d, output logic [1:0] r);
        bit seen;
        logic [31:0] d0;
        logic [1:0]  r0;
        seen = 0; d = 32'hDEADBEEF; r = 2'b11;
        @(negedge clk);
        s_araddr = a; s_arvalid = 1; s_rready = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (s_arready) begin seen = 1; break; end
        end
        check("arready_seen", 32'(seen), 32'd1);
        if (!seen) begin s_arvalid = 0; return; end
        rd_fire = 1; rd_addr = a;
        if (dr) begin sensor_rand(); data_ready = 1; end
        @(negedge clk);
        s_arvalid = 0; rd_fire = 0; data_ready = 0;
        check("rvalid", 32'(s_rvalid), 32'd1);
        check("rdata", s_rdata, exp_rdata);
        check("rresp", 32'(s_rresp), 32'(exp_rresp));
        d0 = s_rdata; r0 = s_rresp;
        repeat (hold) begin
            @(negedge clk);
            check("rvalid_hold", 32'(s_rvalid), 32'd1);
            check("rdata_hold", s_rdata, d0);
            check("rresp_hold", 32'(s_rresp), 32'(r0));
        end
        s_rready = 1;
        @(negedge clk);
        s_rready = 0;
        check("rvalid_clr", 32'(s_rvalid), 32'd0);
        d = d0; r = r0;
    endtask

    initial begin : stim
        logic [31:0] d;
        logic [1:0]  r;
        int          sel;
        logic [4:0]  a;
        arstn = 0; s_awaddr = 0; s_awvalid = 0; s_wdata = 0; s_wstrb = 0; s_wvalid = 0;
        s_bready = 0; s_araddr = 0; s_arvalid = 0; s_rready = 0; data_ready = 0; sys_idle = 1;
        humidity_bcd = 0; temperature_bcd = 0; negativo_temp = 0; parity = 0;
        wr_fire = 0; rd_fire = 0; wr_addr = 0; rd_addr = 0; wr_data = 0; wr_strb = 0;

        repeat (3) @(negedge clk);
        check("rst_awready", 32'(s_awready), 32'd0);
        check("rst_arready", 32'(s_arready), 32'd0);
        check("rst_bvalid", 32'(s_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_rdata", s_rdata, 32'd0);
        check("rst_resp", {28'd0, s_bresp, s_rresp}, 32'd0);
        check("rst_start", 32'(start_read), 32'd0);
        arstn = 1;

        // Reset register contents
        axi_read(5'h00, 0, 0, d, r); check("lit_ctrl", d, 32'd0); check("lit_ctrl_resp", 32'(r), 32'd0);
        axi_read(5'h04, 0, 0, d, r); check("lit_status", d, 32'd1);
        axi_read(5'h0C, 0, 0, d, r); check("lit_period", d, 32'd2000);
        axi_read(5'h10, 0, 0, d, r); check("lit_count", d, 32'd0);

        // START while the driver is busy, then release
        sys_idle = 0;
        axi_write(5'h00, 32'h1, 4'hF, 0, 0, r);
        axi_read(5'h04, 0, 0, d, r); check("lit_status_pend", d, 32'h4);
        repeat (10) @(negedge clk);
        sys_idle = 1;
        @(negedge clk); check("lit_start_hi", 32'(start_read), 32'd1);
        @(negedge clk); check("lit_start_lo", 32'(start_read), 32'd0);
        axi_read(5'h04, 0, 0, d, r); check("lit_status_idle", d, 32'h1);

        // Capture of a known reading
        @(negedge clk);
        humidity_bcd = 12'h523; temperature_bcd = 12'h217; negativo_temp = 1; parity = 8'hA5;
        data_ready = 1;
        @(negedge clk);
        data_ready = 0;
        axi_read(5'h08, 0, 0, d, r); check("lit_data", d, 32'h82170523);
        axi_read(5'h14, 0, 0, d, r); check("lit_parity", d, 32'hA5);
        axi_read(5'h04, 0, 0, d, r); check("lit_status_valid", d, 32'h3);
        axi_read(5'h10, 0, 0, d, r); check("lit_count1", d, 32'd1);

        // W1C racing a capture, then W1C alone
        axi_write(5'h04, 32'h2, 4'hF, 0, 1, r);
        axi_read(5'h04, 0, 0, d, r); check("lit_w1c_race", d, 32'h3);
        axi_read(5'h10, 0, 0, d, r); check("lit_count2", d, 32'd2);
        axi_write(5'h04, 32'h2, 4'hF, 0, 0, r);
        axi_read(5'h04, 0, 0, d, r); check("lit_w1c", d, 32'h1);

        // DATA read in the capture cycle, error responses, stalled responses
        axi_read(5'h08, 0, 1, d, r);
        axi_read(5'h18, 5, 0, d, r); check("lit_unmapped_data", d, 32'd0); check("lit_unmapped_resp", 32'(r), 32'd2);
        axi_read(5'h06, 0, 0, d, r); check("lit_misaligned_resp", 32'(r), 32'd2);
        axi_write(5'h08, 32'hFFFFFFFF, 4'hF, 5, 0, r); check("lit_ro_wr_resp", 32'(r), 32'd0);
        axi_read(5'h08, 5, 0, d, r);
        axi_write(5'h1C, 32'h1, 4'hF, 0, 0, r); check("lit_unmapped_wr", 32'(r), 32'd2);

        // PERIOD clamping and strobes
        axi_write(5'h0C, 32'd10, 4'hF, 0, 0, r);
        axi_read(5'h0C, 0, 0, d, r); check("lit_clamp", d, 32'd2000);
        axi_write(5'h0C, 32'h12345678, 4'b0011, 0, 0, r);
        axi_read(5'h0C, 0, 0, d, r); check("lit_strb", d, 32'h00005678);
        axi_write(5'h0C, 32'hFFFF0000, 4'b0011, 0, 0, r);
        axi_read(5'h0C, 0, 0, d, r); check("lit_strb_clamp", d, 32'd2000);

        // Auto-trigger every PERIOD cycles
        pulse_q.delete();
        axi_write(5'h00, 32'h2, 4'hF, 0, 0, r);
        repeat (6300) @(negedge clk);
        axi_write(5'h00, 32'h0, 4'hF, 0, 0, r);
        check("lit_auto_pulses", 32'(pulse_q.size()), 32'd3);
        if (pulse_q.size() == 3) begin
            check("lit_auto_gap1", 32'(pulse_q[1] - pulse_q[0]), 32'd2000);
            check("lit_auto_gap2", 32'(pulse_q[2] - pulse_q[1]), 32'd2000);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 9));
            a = (sel < 8) ? 5'(sel * 4) : 5'($urandom);
            case ($urandom_range(0, 3))
                0: axi_read(a, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)), d, r);
                1: begin
                    if ($urandom_range(0, 1) == 1) a = 5'h0C;
                    d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 4000)) : $urandom;
                    axi_write(a, d, 4'($urandom), int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)), r);
                end
                2: axi_write(($urandom_range(0, 1) == 1) ? 5'h00 : 5'h04, $urandom, 4'hF, 0,
                             bit'($urandom_range(0, 1)), r);
                default: begin
                    repeat ($urandom_range(1, 6)) begin
                        @(negedge clk);
                        sensor_rand();
                        data_ready = ($urandom_range(0, 3) == 0);
                        sys_idle   = ($urandom_range(0, 7) != 0);
                    end
                    @(negedge clk);
                    data_ready = 0;
                end
            endcase
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_dht22_regs.md
Name: axi_lite_dht22_regs

Overview:
- AXI4-Lite slave register bank sitting directly downstream of the DHT22 top.
- Consumes its data_ready pulse, BCD humidity and temperature, sign bit, parity byte and sys_idle.
- Produces its start_read pulse, triggered either by a software command or by an auto-trigger timer.
- Snapshots each valid reading atomically so the CPU never reads a torn humidity/temperature pair.

Parameters:
- CLK_FREQ, 100000000, clk frequency in Hz; sets the minimum sensor polling interval.
- MIN_PERIOD, 2*CLK_FREQ, smallest legal auto-trigger interval in clk cycles; the DHT22 limit is 2 s.

Ports:
- clk  in  1  system clock
- arstn  in  1  asynchronous active-low reset
- s_awaddr  in  5  write address (byte)
- s_awvalid / s_awready  in / out  1  write address handshake
- s_wdata  in  32  write data
- s_wstrb  in  4  byte strobes
- s_wvalid / s_wready  in / out  1  write data handshake
- s_bresp  out  2  write response
- s_bvalid / s_bready  out / in  1  write response handshake
- s_araddr  in  5  read address
- s_arvalid / s_arready  in / out  1  read address handshake
- s_rdata  out  32  read data
- s_rresp  out  2  read response
- s_rvalid / s_rready  out / in  1  read data handshake
- start_read  out  1  one-cycle request to the sensor driver
- data_ready  in  1  one-cycle pulse: new CRC-correct reading
- sys_idle  in  1  sensor driver idle
- humidity_bcd  in  12  {tens, units, tenths}
- temperature_bcd  in  12  {tens, units, tenths}
- negativo_temp  in  1  temperature sign
- parity  in  8  received checksum byte

Behaviour:
- Reset: all AXI ready/valid low, bresp/rresp 0, rdata 0, start_read 0.
- Reset register state: CTRL 0, STATUS.valid 0, DATA 0, PARITY 0, COUNT 0, PERIOD = MIN_PERIOD, timer 0, pending 0.
- Register map:
  - 0x00 CTRL: bit0 START (write-1 sets pending, reads 0); bit1 AUTO_EN (RW).
  - 0x04 STATUS: bit0 sys_idle (live); bit1 VALID (sticky, write-1-to-clear); bit2 PENDING.
  - 0x08 DATA: [11:0] humidity_bcd, [27:16] temperature_bcd, [31] negativo_temp. Snapshot, RO.
  - 0x0C PERIOD: 32-bit RW; writes below MIN_PERIOD store MIN_PERIOD.
  - 0x10 COUNT: 32-bit RO; readings captured, wraps 0xFFFFFFFF -> 0.
  - 0x14 PARITY: [7:0] snapshot, RO.
- Write channel:
  - Accept only when awvalid and wvalid are both high and bvalid is low; awready and wready pulse together for 1 cycle.
  - bvalid asserts the next cycle and holds until bready.
  - wstrb is honoured per byte on CTRL and PERIOD; clamping is applied after the strobe merge.
  - Writes to RO registers: ignored, OKAY.
  - Unmapped address or addr[1:0] != 0: SLVERR, no effect.
- Read channel:
  - arready pulses 1 cycle when arvalid and !rvalid.
  - rvalid asserts the next cycle; rdata and rresp stay stable until rready.
  - Unmapped address: rdata 0, SLVERR.
  - At most one read and one write outstanding; the read and write paths operate independently.
- Trigger logic:
  - pending is set by a START write or by timer expiry.
  - When pending and sys_idle: start_read = 1 for exactly one cycle, pending clears the same cycle.
  - A START while pending is already set is absorbed (no double trigger).
  - Timer: increments each cycle while AUTO_EN=1. At timer == PERIOD-1 it reloads 0 and sets pending. Clears to 0 when AUTO_EN=0.
- Capture: on data_ready, the same edge loads DATA and PARITY, sets VALID and increments COUNT.
- Simultaneous events:
  - data_ready in the same cycle as a STATUS W1C of VALID: set wins, VALID stays 1.
  - Read of DATA in the capture cycle returns the pre-capture value (rdata registered at the AR handshake).
- arstn asserted mid-transaction aborts all handshakes; no response is owed after reset.

Decomposition:
- Package dht22_pkg holds:
  - register offset localparams;
  - CTRL/STATUS bit indices;
  - AXI response codes OKAY=2'b00, SLVERR=2'b10;
  - packed struct dht22_sample_t {neg, temp_bcd[11:0], hum_bcd[11:0], parity[7:0]}.
- One sub-module, dht22_trigger_sched: timer, pending flag and start_read generation.

Test Plan:
- Reset -> reads give CTRL=0, STATUS=0x1 (sys_idle=1), PERIOD=MIN_PERIOD, COUNT=0; all with OKAY.
- CTRL=0x1 written with sys_idle=0 for 10 cycles, then 1 -> no start_read while busy; one start_read pulse the cycle after sys_idle rises; STATUS.PENDING returns to 0.
- data_ready with hum=0x523, temp=0x217, neg=1, parity=0xA5 -> DATA=0x82170523, PARITY=0xA5, STATUS bit1=1, COUNT=1.
- STATUS W1C of bit1 in the same cycle as a data_ready pulse -> VALID reads 1, COUNT increments.
- CLK_FREQ=1000; PERIOD written 10 -> reads back 2000. AUTO_EN=1 with sys_idle=1 -> start_read pulses at cycles 2000, 4000, 6000 after enable.
- Read 0x18 -> SLVERR, rdata 0. Write 0x08 -> OKAY, DATA unchanged. Hold bready and rready low 5 cycles -> bvalid/rvalid and rdata remain stable.
